// File: rtl/spi_slave.sv
// SPI slave byte transceiver: SCLK, MOSI and CS_n are oversampled in the i_Clk
// domain; bytes are received and transmitted MSB first.
module spi_slave #(
   parameter int unsigned SPI_MODE = 0
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_SPI_Clk,
   output logic       o_SPI_MISO,
   input  logic       i_SPI_MOSI,
   input  logic       i_SPI_CS_n
);

   localparam logic [1:0] MODE_BITS = 2'(SPI_MODE);
   localparam logic       CPOL      = MODE_BITS[1];
   localparam logic       CPHA      = MODE_BITS[0];

   logic       sclk_meta_q, sclk_meta_d;
   logic       sclk_sync_q, sclk_sync_d;
   logic       sclk_prev_q, sclk_prev_d;
   logic       mosi_meta_q, mosi_meta_d;
   logic       mosi_sync_q, mosi_sync_d;
   logic       csn_meta_q,  csn_meta_d;
   logic       csn_sync_q,  csn_sync_d;
   logic       csn_prev_q,  csn_prev_d;
   logic [2:0] bit_cnt_q,   bit_cnt_d;
   logic [6:0] rx_shift_q,  rx_shift_d;
   logic [7:0] rx_byte_q,   rx_byte_d;
   logic       rx_dv_q,     rx_dv_d;
   logic [7:0] tx_hold_q,   tx_hold_d;
   logic [6:0] tx_shift_q,  tx_shift_d;
   logic       miso_q,      miso_d;

   logic       sclk_edge;
   logic       lead_edge;
   logic       trail_edge;
   logic       sample_edge;
   logic       shift_edge;
   logic       csn_fall;
   logic [7:0] tx_load_val;
   logic       tx_load;
   logic       tx_shift_en;

   always_comb begin
      sclk_meta_d = i_SPI_Clk;
      sclk_sync_d = sclk_meta_q;
      sclk_prev_d = sclk_sync_q;
      mosi_meta_d = i_SPI_MOSI;
      mosi_sync_d = mosi_meta_q;
      csn_meta_d  = i_SPI_CS_n;
      csn_sync_d  = csn_meta_q;
      csn_prev_d  = csn_sync_q;

      sclk_edge   = sclk_sync_q != sclk_prev_q;
      lead_edge   = sclk_edge && (sclk_prev_q == CPOL);
      trail_edge  = sclk_edge && (sclk_prev_q != CPOL);
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge : trail_edge;
      csn_fall    = csn_prev_q && !csn_sync_q;
      // A byte written in the load cycle itself bypasses the holding register.
      tx_load_val = i_TX_DV ? i_TX_Byte : tx_hold_q;

      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_byte_d   = rx_byte_q;
      rx_dv_d     = 1'b0;
      tx_hold_d   = tx_load_val;
      tx_shift_d  = tx_shift_q;
      miso_d      = miso_q;
      tx_load     = 1'b0;
      tx_shift_en = 1'b0;

      if (csn_sync_q) begin
         bit_cnt_d = '0;
         miso_d    = 1'b1;
      end else begin
         if (sample_edge) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_sync_q};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               rx_byte_d = {rx_shift_q, mosi_sync_q};
               rx_dv_d   = 1'b1;
            end
         end
         // A zero count on a shift edge marks the start of a byte.
         if (!CPHA && csn_fall) begin
            tx_load = 1'b1;
         end else if (shift_edge) begin
            if (bit_cnt_q == '0) begin
               tx_load = 1'b1;
            end else begin
               tx_shift_en = 1'b1;
            end
         end
         if (tx_load) begin
            miso_d     = tx_load_val[7];
            tx_shift_d = tx_load_val[6:0];
         end else if (tx_shift_en) begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sclk_meta_q <= CPOL;
         sclk_sync_q <= CPOL;
         sclk_prev_q <= CPOL;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         csn_meta_q  <= 1'b1;
         csn_sync_q  <= 1'b1;
         csn_prev_q  <= 1'b1;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         rx_byte_q   <= '0;
         rx_dv_q     <= 1'b0;
         tx_hold_q   <= '1;
         tx_shift_q  <= '1;
         miso_q      <= 1'b1;
      end else begin
         sclk_meta_q <= sclk_meta_d;
         sclk_sync_q <= sclk_sync_d;
         sclk_prev_q <= sclk_prev_d;
         mosi_meta_q <= mosi_meta_d;
         mosi_sync_q <= mosi_sync_d;
         csn_meta_q  <= csn_meta_d;
         csn_sync_q  <= csn_sync_d;
         csn_prev_q  <= csn_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_dv_q     <= rx_dv_d;
         tx_hold_q   <= tx_hold_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
      end
   end

   assign o_RX_DV    = rx_dv_q;
   assign o_RX_Byte  = rx_byte_q;
   assign o_SPI_MISO = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 and a mode-3 instance driven by a bit-banged
// SPI master; expected bytes come from the master's own view of the link.
module tb_spi_slave;

   logic       clk;
   logic       rst;
   logic       txdv;
   logic [7:0] txbyte;
   logic       sclk [2];
   logic       mosi [2];
   logic       csn  [2];
   logic       dv0, dv1;
   logic [7:0] rxb0, rxb1;
   logic       miso0, miso1;

   int         vectors;
   int         miscompares;
   int         cyc;
   int         dv_cyc [2];
   logic [7:0] rxq0 [$];
   logic [7:0] rxq1 [$];
   logic [7:0] hold_m;

   spi_slave #(.SPI_MODE(0)) u_dut_m0 (
      .i_Clk(clk), .i_Rst(rst), .o_RX_DV(dv0), .o_RX_Byte(rxb0),
      .i_TX_DV(txdv), .i_TX_Byte(txbyte), .i_SPI_Clk(sclk[0]),
      .o_SPI_MISO(miso0), .i_SPI_MOSI(mosi[0]), .i_SPI_CS_n(csn[0])
   );

   spi_slave #(.SPI_MODE(3)) u_dut_m3 (
      .i_Clk(clk), .i_Rst(rst), .o_RX_DV(dv1), .o_RX_Byte(rxb1),
      .i_TX_DV(txdv), .i_TX_Byte(txbyte), .i_SPI_Clk(sclk[1]),
      .o_SPI_MISO(miso1), .i_SPI_MOSI(mosi[1]), .i_SPI_CS_n(csn[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Every high cycle of o_RX_DV counts as one delivered byte.
   always @(negedge clk) begin
      if (dv0) begin
         rxq0.push_back(rxb0);
         dv_cyc[0] = cyc;
      end
      if (dv1) begin
         rxq1.push_back(rxb1);
         dv_cyc[1] = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_tx(input logic [7:0] b);
      txdv   = 1'b1;
      txbyte = b;
      hold_m = b;
      tick(1);
      txdv   = 1'b0;
   endtask

   task automatic cs_low(input int m);
      csn[m] = 1'b0;
      tick(6);
   endtask

   task automatic cs_high(input int m);
      tick(2);
      csn[m] = 1'b1;
      tick(6);
   endtask

   // Master side: half period of 4 i_Clk cycles, MISO read at the sample edge.
   task automatic shift_bits(input int m, input logic [7:0] b, input int nbits,
                             output logic [7:0] got, output int edge_at);
      got     = '0;
      edge_at = 0;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (m == 0) begin
            mosi[0] = b[i];
            tick(4);
            got[i]  = miso0;
            sclk[0] = 1'b1;
            edge_at = cyc;
            tick(4);
            sclk[0] = 1'b0;
         end else begin
            sclk[1] = 1'b0;
            mosi[1] = b[i];
            tick(4);
            got[i]  = miso1;
            sclk[1] = 1'b1;
            edge_at = cyc;
            tick(4);
         end
      end
   endtask

   task automatic xfer_check(input int m, input logic [7:0] b, input string tag);
      logic [7:0] got;
      logic [7:0] r;
      int         e8;
      int         n;
      shift_bits(m, b, 8, got, e8);
      r = 'x;
      if (m == 0) begin
         n = rxq0.size();
         if (n > 0) r = rxq0[0];
         rxq0.delete();
      end else begin
         n = rxq1.size();
         if (n > 0) r = rxq1[0];
         rxq1.delete();
      end
      chk({tag, "_dv_count"}, n, 1);
      chk({tag, "_rx_byte"}, r, b);
      chk({tag, "_miso_byte"}, got, hold_m);
      chk({tag, "_dv_latency"}, dv_cyc[m] - e8, 3);
   endtask

   initial begin
      logic [7:0] junk;
      int         e8;
      int         nbytes;

      vectors     = 0;
      miscompares = 0;
      rst     = 1'b1;
      txdv    = 1'b0;
      txbyte  = '0;
      sclk[0] = 1'b0;
      sclk[1] = 1'b1;
      mosi[0] = 1'b0;
      mosi[1] = 1'b0;
      csn[0]  = 1'b1;
      csn[1]  = 1'b1;
      dv_cyc[0] = 0;
      dv_cyc[1] = 0;
      tick(3);
      chk("rst_dv_m0", dv0, 0);
      chk("rst_rx_m0", rxb0, 8'h00);
      chk("rst_miso_m0", miso0, 1);
      chk("rst_dv_m3", dv1, 0);
      chk("rst_rx_m3", rxb1, 8'h00);
      chk("rst_miso_m3", miso1, 1);
      rst    = 1'b0;
      hold_m = 8'hFF;
      tick(2);

      write_tx(8'h3C);
      cs_low(0);
      xfer_check(0, 8'hA5, "m0_a5");
      cs_high(0);
      chk("m0_idle_miso", miso0, 1);

      cs_low(0);
      xfer_check(0, 8'h03, "b2b_03");
      xfer_check(0, 8'h00, "b2b_00a");
      xfer_check(0, 8'h00, "b2b_00b");
      xfer_check(0, 8'h10, "b2b_10");
      txdv   = 1'b1;
      txbyte = 8'hEF;
      hold_m = 8'hEF;
      xfer_check(0, 8'($urandom), "b2b_5th");
      txdv   = 1'b0;
      cs_high(0);

      cs_low(0);
      shift_bits(0, 8'hFF, 5, junk, e8);
      cs_high(0);
      chk("partial_no_dv", rxq0.size(), 0);
      cs_low(0);
      xfer_check(0, 8'h5A, "after_partial");
      cs_high(0);
      chk("rx_byte_retained", rxb0, 8'h5A);

      write_tx(8'h7E);
      cs_low(1);
      xfer_check(1, 8'h81, "m3_81");
      cs_high(1);
      chk("m3_idle_miso", miso1, 1);

      cs_low(0);
      shift_bits(0, 8'hC3, 4, junk, e8);
      rst = 1'b1;
      tick(1);
      chk("midrst_dv", dv0, 0);
      chk("midrst_rx", rxb0, 8'h00);
      chk("midrst_miso", miso0, 1);
      rst    = 1'b0;
      hold_m = 8'hFF;
      cs_high(0);
      rxq0.delete();
      cs_low(0);
      xfer_check(0, 8'h96, "post_rst");
      cs_high(0);

      for (int m = 0; m < 2; m++) begin
         for (int s = 0; s < 3; s++) begin
            if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
            cs_low(m);
            nbytes = int'($urandom_range(1, 3));
            for (int k = 0; k < nbytes; k++) begin
               if (k > 0 && $urandom_range(0, 1) == 1) write_tx(8'($urandom));
               xfer_check(m, 8'($urandom), "random");
            end
            cs_high(m);
         end
      end

      tick(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
